// File: rtl/studio_keypad_ctrl.sv
// Keypad front end for the Studio II core: PS/2 key events to one or two ten-key pads,
// CPU-written key-select latch, registered per-pad EF flags and a minimum key-hold stretch.
module studio_keypad_ctrl #(
    parameter int NUM_PADS = 2,
    parameter int MIN_HOLD = 65536,
    parameter int SEL_PORT = 2
) (
    input  logic                     clk,
    input  logic                     resetq,
    input  logic [10:0]              ps2_key,
    input  logic                     io_out,
    input  logic [2:0]               io_n,
    input  logic [7:0]               io_dout,
    output logic [NUM_PADS-1:0]      ef,
    output logic [3:0]               key_sel,
    output logic [10*NUM_PADS-1:0]   key_state,
    output logic                     any_pressed
);

    localparam int NK = 10 * NUM_PADS;
    localparam int CW = (MIN_HOLD > 0) ? $clog2(MIN_HOLD + 1) : 1;

    logic       tog_q;
    logic       armed;
    logic       map_hit;
    logic       map_pad;
    logic [3:0] map_digit;
    logic       pad_ok;
    logic       key_event;
    logic       unused_ok;

    assign unused_ok = ^io_dout[7:4];

    // armed keeps the first clk after reset from comparing against a cleared shadow
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            tog_q <= 1'b0;
            armed <= 1'b0;
        end else begin
            tog_q <= ps2_key[10];
            armed <= 1'b1;
        end
    end

    always_comb begin
        map_hit   = 1'b1;
        map_pad   = 1'b0;
        map_digit = 4'd0;
        case (ps2_key[7:0])
            8'h45: map_digit = 4'd0;
            8'h16: map_digit = 4'd1;
            8'h1E: map_digit = 4'd2;
            8'h26: map_digit = 4'd3;
            8'h25: map_digit = 4'd4;
            8'h2E: map_digit = 4'd5;
            8'h36: map_digit = 4'd6;
            8'h3D: map_digit = 4'd7;
            8'h3E: map_digit = 4'd8;
            8'h46: map_digit = 4'd9;
            8'h70: begin map_pad = 1'b1; map_digit = 4'd0; end
            8'h69: begin map_pad = 1'b1; map_digit = 4'd1; end
            8'h72: begin map_pad = 1'b1; map_digit = 4'd2; end
            8'h7A: begin map_pad = 1'b1; map_digit = 4'd3; end
            8'h6B: begin map_pad = 1'b1; map_digit = 4'd4; end
            8'h73: begin map_pad = 1'b1; map_digit = 4'd5; end
            8'h74: begin map_pad = 1'b1; map_digit = 4'd6; end
            8'h6C: begin map_pad = 1'b1; map_digit = 4'd7; end
            8'h75: begin map_pad = 1'b1; map_digit = 4'd8; end
            8'h7D: begin map_pad = 1'b1; map_digit = 4'd9; end
            default: map_hit = 1'b0;
        endcase
    end

    assign pad_ok    = (map_pad == 1'b0) || (NUM_PADS > 1);
    assign key_event = armed && (ps2_key[10] != tog_q) && !ps2_key[8] && map_hit && pad_ok;

    for (genvar k = 0; k < NK; k++) begin : g_key
        logic key_q;
        logic hit;

        assign hit = key_event && (map_pad == 1'(k / 10)) && (map_digit == 4'(k % 10));

        if (MIN_HOLD > 0) begin : g_hold
            logic [CW-1:0] cnt;
            logic          pend;

            // a release landing on the last hold cycle clears at once, since the counter ends this clk
            always_ff @(posedge clk or negedge resetq) begin
                if (!resetq) begin
                    key_q <= 1'b0;
                    cnt   <= '0;
                    pend  <= 1'b0;
                end else if (hit && ps2_key[9]) begin
                    key_q <= 1'b1;
                    cnt   <= CW'(MIN_HOLD);
                    pend  <= 1'b0;
                end else begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end
                    if (hit) begin
                        if (cnt <= CW'(1)) begin
                            key_q <= 1'b0;
                            pend  <= 1'b0;
                        end else begin
                            pend  <= 1'b1;
                        end
                    end else if (pend && (cnt == CW'(1))) begin
                        key_q <= 1'b0;
                        pend  <= 1'b0;
                    end
                end
            end
        end else begin : g_direct
            always_ff @(posedge clk or negedge resetq) begin
                if (!resetq) begin
                    key_q <= 1'b0;
                end else if (hit) begin
                    key_q <= ps2_key[9];
                end
            end
        end

        assign key_state[k] = key_q;
    end

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            key_sel <= 4'd0;
        end else if (io_out && (io_n == 3'(SEL_PORT))) begin
            key_sel <= io_dout[3:0];
        end
    end

    // zero-padding to 16 entries makes select values 10..15 read as not pressed
    logic [15:0] pad_bits [NUM_PADS];
    for (genvar p = 0; p < NUM_PADS; p++) begin : g_pad
        assign pad_bits[p] = {6'd0, key_state[p*10 +: 10]};
    end

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            ef          <= '0;
            any_pressed <= 1'b0;
        end else begin
            for (int p = 0; p < NUM_PADS; p++) begin
                ef[p] <= pad_bits[p][key_sel];
            end
            any_pressed <= |key_state;
        end
    end

endmodule

// File: doc/studio_keypad_ctrl.md
Name: studio_keypad_ctrl

Overview:
- Parametrised keypad front end for the Studio II core; replaces the ad-hoc single-pad key registers in the top level.
- Decodes PS/2 key events into 1 or 2 ten-key pads.
- Holds a CPU-written key-select latch.
- Drives one registered per-pad flag for the 1802 EF inputs: EF3 for pad 0, EF4 for pad 1.
- Enforces a minimum key-hold time so short taps survive frame-rate software polling.

Parameters:
- NUM_PADS, 2, number of pads (legal 1..2); pad 0 = top-row digits, pad 1 = numeric keypad digits.
- MIN_HOLD, 65536, minimum cycles a key reads pressed after a press event (0 = release immediately).
- SEL_PORT, 2, 1802 N value (io_n) whose OUT cycle writes the key-select latch.

Ports:
- clk  in  1  system clock
- resetq  in  1  asynchronous active-low reset
- ps2_key  in  11  [10] toggle strobe, [9] pressed, [8] extended, [7:0] scan code
- io_out  in  1  CPU OUT strobe, one cycle
- io_n  in  3  CPU N lines
- io_dout  in  8  CPU output data
- ef  out  NUM_PADS  per-pad "selected key pressed" flag, active-high
- key_sel  out  4  current select latch
- key_state  out  10*NUM_PADS  held state; bit p*10+k = pad p, digit k
- any_pressed  out  1  OR of key_state

Behaviour:
- Reset (resetq=0, async): ef=0, key_sel=0, key_state=0, any_pressed=0. Hold counters, pending flags and the toggle shadow all clear. The toggle shadow loads ps2_key[10] on the first clk after release, so no spurious event fires.
- Event detect: event = ps2_key[10] differs from its registered copy. Exactly one event is processed per toggle.
- Events with ps2_key[8]=1 are ignored.
- Pad 0 digit map: 45→0, 16→1, 1E→2, 26→3, 25→4, 2E→5, 36→6, 3D→7, 3E→8, 46→9.
- Pad 1 digit map: 70→0, 69→1, 72→2, 7A→3, 6B→4, 73→5, 74→6, 6C→7, 75→8, 7D→9. Ignored when NUM_PADS=1.
- Unmapped codes are ignored.
- Each key has a hold counter of width clog2(MIN_HOLD+1) and a release-pending flag.
- Press event: key_state bit=1, counter=MIN_HOLD, pending=0. Takes effect on the same clk the event is detected.
- Release event:
  - If counter=0, the key bit clears on that clk.
  - Otherwise pending=1, and the bit clears on the clk the counter decrements from 1 to 0.
- Counter decrements by 1 per clk while nonzero; it saturates at 0.
- Re-press while pending reloads the counter and clears pending.
- Duplicate press events (typematic repeat) reload the counter.
- A release with no prior press is harmless: the bit stays 0.
- MIN_HOLD=0: no counters are inferred; state follows the events directly.
- Select latch: when io_out=1 and io_n==SEL_PORT, key_sel <= io_dout[3:0] on that clk. Other N values and other data bits are ignored.
- ef[p] is registered: ef[p] <= (key_sel<=9) ? key_state[p*10+key_sel] : 0.
  - Latency is 1 clk from a key_state or key_sel change to ef.
  - key_sel values 10..15 give ef=0.
- any_pressed is registered with the same 1-clk latency.
- Simultaneous select write and key event: both update on the same clk. ef reflects both one clk later.
- Pad keys are independent, so holding multiple keys is legal. ef reports only the selected key.
- Reset asserted mid-hold clears everything immediately. A pending release is discarded.

Test Plan:
- Reset, then hold ps2_key static across resetq rising → no event; ef=0, key_sel=0, key_state=0.
- Write: io_n=2, io_dout=8'h05, io_out pulse; then press 0x2E → key_state[5]=1 on event clk; ef[0]=1 one clk later; ef[1]=0.
- MIN_HOLD=16: press 0x16, release 4 clk later, key_sel=1 → ef[0] stays 1 until 16 clk after the press, then drops one clk after key_state[1] clears.
- Pad 1: key_sel=7, press 0x6C → ef[1]=1, ef[0]=0. Same code with ps2_key[8]=1 → no change.
- key_sel written to 0xC with key 0x46 held → ef=0. Rewrite key_sel=9 on the same clk as a new 0x45 press → next clk ef[0]=1 and key_state[0]=1.
- Press 0x1E, release with 10 clk of hold remaining, re-press 3 clk later → counter reloads to MIN_HOLD and the key never drops. Assert resetq=0 mid-hold → all outputs 0 asynchronously.
